// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters, registered sync/visible
// flags aligned with the counters, current/next pixel coordinates, frame count.
module vga_timing #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter bit SYNC_ACTIVE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic [(SCREEN_WIDTH  > 1 ? $clog2(SCREEN_WIDTH)  : 1)-1:0] position_x,
    output logic [(SCREEN_HEIGHT > 1 ? $clog2(SCREEN_HEIGHT) : 1)-1:0] position_y,
    output logic [(SCREEN_WIDTH  > 1 ? $clog2(SCREEN_WIDTH)  : 1)-1:0] position_x_next,
    output logic [(SCREEN_HEIGHT > 1 ? $clog2(SCREEN_HEIGHT) : 1)-1:0] position_y_next,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic [31:0] frame
);
    localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = SCREEN_WIDTH  > 1 ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = SCREEN_HEIGHT > 1 ? $clog2(SCREEN_HEIGHT) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(SCREEN_WIDTH);
    localparam logic [VW-1:0] V_VIS    = VW'(SCREEN_HEIGHT);
    localparam logic [HW-1:0] HS_START = HW'(SCREEN_WIDTH + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(SCREEN_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(SCREEN_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(SCREEN_HEIGHT + V_FRONT + V_SYNC);

    logic [HW-1:0] h_count, h_count_next;
    logic [VW-1:0] v_count, v_count_next;
    logic          h_wrap, v_wrap;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    always_comb begin
        h_count_next = h_wrap ? '0 : h_count + 1'b1;
        v_count_next = v_count;
        if (h_wrap)
            v_count_next = v_wrap ? '0 : v_count + 1'b1;
    end

    // Blanking columns/lines report coordinate 0 so image sources see a stable index.
    assign position_x      = (h_count < H_VIS)      ? h_count[XW-1:0]      : '0;
    assign position_y      = (v_count < V_VIS)      ? v_count[YW-1:0]      : '0;
    assign position_x_next = (h_count_next < H_VIS) ? h_count_next[XW-1:0] : '0;
    assign position_y_next = (v_count_next < V_VIS) ? v_count_next[YW-1:0] : '0;

    // Flags are computed from the next counter values so they land in the same
    // cycle as the counters they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
            frame   <= '0;
            visible <= 1'b1;
            hsync   <= ~SYNC_ACTIVE;
            vsync   <= ~SYNC_ACTIVE;
        end else begin
            h_count <= h_count_next;
            v_count <= v_count_next;
            visible <= (h_count_next < H_VIS) && (v_count_next < V_VIS);
            hsync   <= (h_count_next >= HS_START && h_count_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync   <= (v_count_next >= VS_START && v_count_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            if (h_wrap && v_wrap)
                frame <= frame + 32'd1;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three configurations checked every cycle against a
// cycle-index model, plus a vector table and pulse-width measurements.
module tb_vga_timing;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cmp_cnt = 0;
    int unsigned err_cnt = 0;

    // D: default timing
    logic [9:0] d_px, d_pxn; logic [8:0] d_py, d_pyn;
    logic d_vis, d_hs, d_vs; logic [31:0] d_fr;
    vga_timing dut_d (.clk(clk), .rst(rst), .position_x(d_px), .position_y(d_py),
        .position_x_next(d_pxn), .position_y_next(d_pyn), .visible(d_vis),
        .hsync(d_hs), .vsync(d_vs), .frame(d_fr));

    // S: tiny raster, active-high syncs
    logic [2:0] s_px, s_pxn; logic [1:0] s_py, s_pyn;
    logic s_vis, s_hs, s_vs; logic [31:0] s_fr;
    vga_timing #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .position_x(s_px), .position_y(s_py),
        .position_x_next(s_pxn), .position_y_next(s_pyn), .visible(s_vis),
        .hsync(s_hs), .vsync(s_vs), .frame(s_fr));

    // C: short lines but default vertical timing, so a whole frame is cheap
    logic [2:0] c_px, c_pxn; logic [8:0] c_py, c_pyn;
    logic c_vis, c_hs, c_vs; logic [31:0] c_fr;
    vga_timing #(.SCREEN_WIDTH(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)) dut_c (
        .clk(clk), .rst(rst), .position_x(c_px), .position_y(c_py),
        .position_x_next(c_pxn), .position_y_next(c_pyn), .visible(c_vis),
        .hsync(c_hs), .vsync(c_vs), .frame(c_fr));

    typedef struct {
        int px, py, pxn, pyn;
        bit vis, hs, vs;
        int unsigned fr;
    } exp_t;

    // Expected outputs t cycles after the last reset edge.
    function automatic exp_t model(int t, int w, int h, int hf, int hs, int hb,
                                   int vf, int vs, int vb, bit sa);
        exp_t m;
        int ht = w + hf + hs + hb;
        int vt = h + vf + vs + vb;
        int hc = t % ht;
        int vc = (t / ht) % vt;
        int hn = (t + 1) % ht;
        int vn = ((t + 1) / ht) % vt;
        m.px  = (hc < w) ? hc : 0;
        m.py  = (vc < h) ? vc : 0;
        m.pxn = (hn < w) ? hn : 0;
        m.pyn = (vn < h) ? vn : 0;
        m.vis = (hc < w) && (vc < h);
        m.hs  = (hc >= w + hf && hc < w + hf + hs) ? sa : !sa;
        m.vs  = (vc >= h + vf && vc < h + vf + vs) ? sa : !sa;
        m.fr  = t / (ht * vt);
        return m;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string nm, exp_t e, int px, int py, int pxn, int pyn,
                           bit vis, bit hs, bit vs, int unsigned fr);
        chk({nm, ".px"}, px, e.px);
        chk({nm, ".py"}, py, e.py);
        chk({nm, ".pxn"}, pxn, e.pxn);
        chk({nm, ".pyn"}, pyn, e.pyn);
        chk({nm, ".vis"}, vis, e.vis);
        chk({nm, ".hsync"}, hs, e.hs);
        chk({nm, ".vsync"}, vs, e.vs);
        chk({nm, ".frame"}, fr, e.fr);
    endtask

    int t = 0;
    bit valid = 0;
    bit have_prev = 0;
    int prev_pxn, prev_pyn;

    // One clock: track cycle index, then check all instances on the falling edge.
    task automatic tick();
        bit rst_edge;
        @(posedge clk);
        rst_edge = rst;
        if (rst) begin t = 0; valid = 1; end
        else t++;
        @(negedge clk);
        if (valid) begin
            chk_all("D", model(t, 640, 480, 16, 96, 48, 10, 2, 33, 1'b0),
                    d_px, d_py, d_pxn, d_pyn, d_vis, d_hs, d_vs, d_fr);
            chk_all("S", model(t, 8, 4, 1, 1, 1, 1, 1, 1, 1'b1),
                    s_px, s_py, s_pxn, s_pyn, s_vis, s_hs, s_vs, s_fr);
            chk_all("C", model(t, 8, 480, 1, 1, 1, 10, 2, 33, 1'b0),
                    c_px, c_py, c_pxn, c_pyn, c_vis, c_hs, c_vs, c_fr);
            if (have_prev && !rst_edge) begin
                chk("S.next_lead_x", s_px, prev_pxn);
                chk("S.next_lead_y", s_py, prev_pyn);
            end
            prev_pxn = s_pxn; prev_pyn = s_pyn; have_prev = 1;
        end
    endtask

    typedef struct {
        int n;
        int px, py, pxn, pyn;
        bit vis, hs, vs;
        int unsigned fr;
    } vec_t;

    initial begin
        vec_t tbl[13];
        int vis_drop = -1, hs_first = -1, hs_cnt = 0, x_seq_bad = 0, d_y_line1 = -1;
        int cvs_first = -1, cvs_cnt = 0, cf1 = -1, shs_cnt = 0, svs_cnt = 0;
        exp_t e;

        tbl[0]  = '{0,   0, 0, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{7,   7, 0, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{8,   0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{9,   0, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{10,  0, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{11,  0, 1, 1, 1, 1, 0, 0, 0};
        tbl[6]  = '{47,  3, 0, 4, 0, 0, 0, 0, 0};
        tbl[7]  = '{58,  3, 0, 4, 0, 0, 0, 1, 0};
        tbl[8]  = '{66,  0, 0, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{76,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{77,  0, 0, 1, 0, 1, 0, 0, 1};
        tbl[11] = '{80,  3, 0, 4, 0, 1, 0, 0, 1};
        tbl[12] = '{163, 0, 0, 0, 0, 0, 1, 0, 2};

        // Power-up reset held for three cycles
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset.d_px", d_px, 0);
        chk("reset.d_pxn", d_pxn, 1);
        chk("reset.d_hsync", d_hs, 1);
        chk("reset.d_frame", d_fr, 0);

        // Measure pulse positions and widths over one C frame
        for (int i = 0; i < 6000; i++) begin
            if (i < 800) begin
                if (!d_vis && vis_drop < 0) vis_drop = i;
                if (!d_hs) begin
                    if (hs_first < 0) hs_first = i;
                    hs_cnt++;
                end
                if (i < 640 && d_px != 10'(i)) x_seq_bad++;
            end
            if (i == 800) d_y_line1 = d_py;
            if (!c_vs) begin
                if (cvs_first < 0) cvs_first = i;
                cvs_cnt++;
            end
            if (c_fr == 1 && cf1 < 0) cf1 = i;
            if (i < 77) begin
                if (s_hs) shs_cnt++;
                if (s_vs) svs_cnt++;
            end
            tick();
        end
        chk("h.visible_drop", vis_drop, 640);
        chk("h.hsync_start", hs_first, 656);
        chk("h.hsync_width", hs_cnt, 96);
        chk("h.x_sequence_errors", x_seq_bad, 0);
        chk("h.next_line_y", d_y_line1, 1);
        chk("v.vsync_start", cvs_first, 490 * 11);
        chk("v.vsync_width", cvs_cnt, 2 * 11);
        chk("v.frame_period", cf1, 525 * 11);
        chk("s.hsync_per_frame", shs_cnt, 7);
        chk("s.vsync_per_frame", svs_cnt, 11);

        // Random reset pulses at arbitrary raster positions
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 300)) tick();
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            rst = 1'b0;
        end

        // Vector table on the small raster
        for (int k = 0; k < 13; k++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat (tbl[k].n) tick();
            e.px = tbl[k].px; e.py = tbl[k].py; e.pxn = tbl[k].pxn; e.pyn = tbl[k].pyn;
            e.vis = tbl[k].vis; e.hs = tbl[k].hs; e.vs = tbl[k].vs; e.fr = tbl[k].fr;
            chk_all($sformatf("tbl%0d", k), e, s_px, s_py, s_pxn, s_pyn, s_vis, s_hs, s_vs, s_fr);
        end

        // Mid-frame reset with frame count 2, line 3, column 5
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (2 * 77 + 3 * 11 + 5) tick();
        chk("mid.frame_before", s_fr, 2);
        chk("mid.px_before", s_px, 5);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid.px", s_px, 0);
        chk("mid.py", s_py, 0);
        chk("mid.frame", s_fr, 0);
        chk("mid.hsync", s_hs, 0);
        chk("mid.vsync", s_vs, 0);
        repeat (100) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA output path. It produces the horizontal and vertical sync pulses, the visible-area flag, and the current and next-cycle pixel coordinates. It also keeps a running frame counter. Pattern/image generators register their colour from the `*_next` coordinates, so their registered RGB lines up with `position_x`/`position_y`, `visible`, `hsync` and `vsync` in the same cycle. The block sits between the pixel clock domain root and every image source.

## Interface
- `SCREEN_WIDTH`, 640, visible pixels per line
- `SCREEN_HEIGHT`, 480, visible lines per frame
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 0, logic level of hsync/vsync while the pulse is asserted
- `clk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `position_x`  out  $clog2(SCREEN_WIDTH)  column of the current cycle
- `position_y`  out  $clog2(SCREEN_HEIGHT)  line of the current cycle
- `position_x_next`  out  $clog2(SCREEN_WIDTH)  value `position_x` takes next cycle
- `position_y_next`  out  $clog2(SCREEN_HEIGHT)  value `position_y` takes next cycle
- `visible`  out  1  current cycle is inside the active area
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `frame`  out  32  completed-frame count

## Operation
- Derived totals:
  - H_TOTAL = SCREEN_WIDTH+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = SCREEN_HEIGHT+V_FRONT+V_SYNC+V_BACK (525 by default).
- Internal counters:
  - `h_count` has $clog2(H_TOTAL) bits; `v_count` has $clog2(V_TOTAL) bits.
  - Both are registers.
  - `h_count_next` and `v_count_next` are combinational.
- Counter advance:
  - `h_count` advances by 1 every cycle.
  - At H_TOTAL-1 it wraps to 0, and `v_count` advances by 1 in the same cycle.
  - `v_count` at V_TOTAL-1 wraps to 0 together with the `h_count` wrap.
- Position outputs (combinational from counters):
  - `position_x` = `h_count` when `h_count` < SCREEN_WIDTH, else 0.
  - `position_y` = `v_count` when `v_count` < SCREEN_HEIGHT, else 0.
  - `*_next` apply the same rule to `h_count_next`/`v_count_next`.
  - Values are truncated to output width.
- `visible` = (`h_count` < SCREEN_WIDTH) && (`v_count` < SCREEN_HEIGHT), registered.
- Sync windows:
  - hsync is asserted (= SYNC_ACTIVE) when `h_count` is in [SCREEN_WIDTH+H_FRONT, SCREEN_WIDTH+H_FRONT+H_SYNC), else !SYNC_ACTIVE.
  - vsync is asserted when `v_count` is in [SCREEN_HEIGHT+V_FRONT, SCREEN_HEIGHT+V_FRONT+V_SYNC), for whole lines.
- Registered flags:
  - `visible`, `hsync` and `vsync` are flops loaded from functions of `h_count_next`/`v_count_next`.
  - They therefore always match the registered counters; no extra cycle of skew.
- Frame counter:
  - `frame` increments by 1 on the cycle both counters wrap to (0,0).
  - It wraps modulo 2^32 with no saturation and no flag.

## Timing
- Reset (`rst`=1 at a clock edge, mid-frame included): next cycle has
  - `h_count`=0, `v_count`=0, position=(0,0), position_next=(1,0)
  - `visible`=1, `hsync`=`vsync`=!SYNC_ACTIVE, `frame`=0
- Reset overrides counter advance, wrap and frame increment in the same cycle.
- Latency:
  - `*_next` lead `position_*` by exactly one cycle.
  - Any consumer registering from `*_next` is aligned with `visible`/syncs.
- Wrap cycle:
  - When position is (SCREEN_WIDTH-1 region, last line) and `h_count`=H_TOTAL-1, `v_count`=V_TOTAL-1, then `*_next`=(0,0).
  - On the following cycle, position=(0,0) and `frame` is already incremented.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles (420000 default).
- Parameters require SCREEN_WIDTH ≥ 2, SCREEN_HEIGHT ≥ 1, and all porches/syncs ≥ 1.

## Test plan
- Reset release:
  - Stimulus: hold `rst` 3 cycles, then release.
  - Response: position (0,0), next (1,0), `visible`=1, hsync=vsync=1 (default SYNC_ACTIVE=0), `frame`=0; position_x counts 0..639 on consecutive cycles.
- Horizontal timing (defaults):
  - `visible` drops at `h_count`=640.
  - `hsync`=0 for exactly 96 cycles, starting 656 cycles after line start.
  - position_x=0 throughout blanking.
  - Next line begins 800 cycles after the previous one, with position_y incremented.
- Vertical timing (defaults):
  - `vsync`=0 for exactly 2×800 cycles starting at line 490.
  - `visible`=0 for lines 480..524.
  - `frame` goes 0→1 exactly 420000 cycles after reset release.
- Small config (W=8, H=4, all porches/syncs=1, SYNC_ACTIVE=1):
  - Checks H_TOTAL=11, V_TOTAL=7, frame period 77.
  - hsync high only at `h_count`=9; vsync high only on line 5.
  - `*_next` equals `position_*` delayed-compare every cycle for 3 frames.
- Reset mid-operation: assert `rst` for 1 cycle at line 300, column 200, `frame`=2 → next cycle position (0,0), `frame`=0, syncs inactive; timing restarts as after power-up.
- Frame wrap: force `frame`=32'hFFFF_FFFF before a frame boundary → it becomes 0 at the boundary, with no other output disturbed.
